// File: rtl/nbody_pkg.sv
// Shared select codes, run-state encoding and STATUS layout for the n-body host interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nbody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING,
        ST_DONE
    } state_t;

    localparam logic [7:0] SEL_GO       = 8'h00;
    localparam logic [7:0] SEL_LOCK     = 8'h01;
    localparam logic [7:0] SEL_N_BODIES = 8'h02;
    localparam logic [7:0] SEL_X        = 8'h03;
    localparam logic [7:0] SEL_Y        = 8'h04;
    localparam logic [7:0] SEL_M        = 8'h05;
    localparam logic [7:0] SEL_VX       = 8'h06;
    localparam logic [7:0] SEL_VY       = 8'h07;
    localparam logic [7:0] SEL_GAP      = 8'h08;
    localparam logic [7:0] SEL_STEPS    = 8'h09;
    localparam logic [7:0] SEL_Z        = 8'h0A;
    localparam logic [7:0] SEL_VZ       = 8'h0B;

    localparam logic [7:0] SEL_STATUS   = 8'h40;
    localparam logic [7:0] SEL_READ_X   = 8'h41;
    localparam logic [7:0] SEL_PERF     = 8'h44;

    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_RUN_BIT  = 1;
    localparam int STAT_ERR_BIT  = 2;
    localparam int STAT_LOCK_BIT = 3;
    localparam int STAT_STEP_LSB = 32;

    function automatic logic [7:0] pos_sel(input int d);
        case (d)
            0:       return SEL_X;
            1:       return SEL_Y;
            default: return SEL_Z;
        endcase
    endfunction

    function automatic logic [7:0] vel_sel(input int d);
        case (d)
            0:       return SEL_VX;
            1:       return SEL_VY;
            default: return SEL_VZ;
        endcase
    endfunction

endpackage

// File: rtl/nbody_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data one cycle after re; held while re is low.
// Backpressure: none; both ports accept every cycle.
module nbody_bank_ram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [1<<ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nbody_host_if.sv
// Host register file, GO/RUN/DONE controller and ping-pong position readout for the n-body core.
// Latency: writes act at the accepting edge; readdata and core_init_* valid one cycle after request.
// Backpressure: none, every bus access accepted; PERF counter only with NBODY_HOST_IF_PERF_CNT_EN.
module nbody_host_if
    import nbody_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 16,
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int DIMS            = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         chipselect,
    input  logic                         read,
    input  logic                         write,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        writedata,
    output logic [DATA_WIDTH-1:0]        readdata,
    output logic                         core_start,
    output logic                         core_stop,
    output logic [BODY_ADDR_WIDTH:0]     core_n_bodies,
    input  logic                         core_busy,
    input  logic                         core_step_done,
    input  logic                         core_init_rd_en,
    input  logic [BODY_ADDR_WIDTH-1:0]   core_init_rd_idx,
    output logic [DIMS*DATA_WIDTH-1:0]   core_init_pos,
    output logic [DIMS*DATA_WIDTH-1:0]   core_init_vel,
    output logic [DATA_WIDTH-1:0]        core_init_mass,
    input  logic                         core_pos_wr_en,
    input  logic [BODY_ADDR_WIDTH-1:0]   core_pos_wr_idx,
    input  logic [DIMS*DATA_WIDTH-1:0]   core_pos_wr_data
);

    localparam int SEL_W  = ADDR_WIDTH - BODY_ADDR_WIDTH;
    localparam int NB_W   = BODY_ADDR_WIDTH + 1;
    localparam int NB_MAX = 1 << BODY_ADDR_WIDTH;

    logic [SEL_W-1:0]           sel;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic                       wr, rd;
    state_t                     state;
    logic [31:0]                gap, gap_eff, steps, step_cnt, gap_cnt;
    logic                       err, lock, swap_pending, bank_sel;
    logic                       rd_pos_q, rd_bank_q;
    logic [1:0]                 rd_dim_q;
    logic [DATA_WIDTH-1:0]      rd_reg_q, status_word, perf_val;
    logic [DIMS*DATA_WIDTH-1:0] front_rd;
    logic                       body_sel, init_we_ok, stepping;
    logic                       go_wr, go_start, go_stop;
    logic                       lock_wr, lock_next, swap_due, do_swap;

    assign sel        = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
    assign idx        = addr[BODY_ADDR_WIDTH-1:0];
    assign wr         = chipselect && write;
    assign rd         = chipselect && read;
    assign init_we_ok = wr && (state != ST_RUN);
    assign stepping   = (state == ST_RUN) || (state == ST_STOPPING);

    assign go_wr    = wr && (sel == SEL_W'(SEL_GO));
    assign go_start = go_wr && writedata[0] && (state == ST_IDLE || state == ST_DONE);
    assign go_stop  = go_wr && !writedata[0];

    // A due swap and a LOCK=1 write in the same cycle leave the swap pending.
    assign gap_eff   = (gap == 32'd0) ? 32'd1 : gap;
    assign swap_due  = stepping && core_step_done && (gap_cnt >= gap_eff - 32'd1);
    assign lock_wr   = wr && (sel == SEL_W'(SEL_LOCK));
    assign lock_next = lock_wr ? writedata[0] : lock;
    assign do_swap   = !lock_next && (swap_due || swap_pending);

    always_comb begin
        body_sel = (sel == SEL_W'(SEL_M));
        for (int d = 0; d < DIMS; d++) begin
            if (sel == SEL_W'(pos_sel(d)) || sel == SEL_W'(vel_sel(d))) begin
                body_sel = 1'b1;
            end
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[STAT_DONE_BIT]           = (state == ST_DONE);
        status_word[STAT_RUN_BIT]            = stepping;
        status_word[STAT_ERR_BIT]            = err;
        status_word[STAT_LOCK_BIT]           = lock;
        status_word[STAT_STEP_LSB +: 32]     = step_cnt;
    end

`ifdef NBODY_HOST_IF_PERF_CNT_EN
    logic [63:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (go_start) begin
            perf_cnt <= '0;
        end else if (stepping) begin
            perf_cnt <= perf_cnt + 64'd1;
        end
    end

    assign perf_val = DATA_WIDTH'(perf_cnt);
`else
    assign perf_val = '0;
`endif

    nbody_bank_ram #(.WIDTH(DATA_WIDTH), .ADDR_W(BODY_ADDR_WIDTH)) u_mass (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (init_we_ok && (sel == SEL_W'(SEL_M))),
        .waddr (idx),
        .wdata (writedata),
        .re    (core_init_rd_en),
        .raddr (core_init_rd_idx),
        .rdata (core_init_mass)
    );

    for (genvar d = 0; d < DIMS; d++) begin : g_dim
        logic                  pos_hit, host_bank_we, core_we0, core_we1;
        logic [DATA_WIDTH-1:0] bank_wdata, bank_rd0, bank_rd1;
        logic [BODY_ADDR_WIDTH-1:0] bank_waddr;

        assign pos_hit      = (sel == SEL_W'(pos_sel(d)));
        // Host position writes in IDLE seed both banks so the first readout is coherent.
        assign host_bank_we = wr && pos_hit && (state == ST_IDLE);
        assign core_we0     = core_pos_wr_en && bank_sel;
        assign core_we1     = core_pos_wr_en && !bank_sel;
        assign bank_wdata   = host_bank_we ? writedata : core_pos_wr_data[d*DATA_WIDTH +: DATA_WIDTH];
        assign bank_waddr   = host_bank_we ? idx : core_pos_wr_idx;

        nbody_bank_ram #(.WIDTH(DATA_WIDTH), .ADDR_W(BODY_ADDR_WIDTH)) u_init_pos (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (init_we_ok && pos_hit),
            .waddr (idx),
            .wdata (writedata),
            .re    (core_init_rd_en),
            .raddr (core_init_rd_idx),
            .rdata (core_init_pos[d*DATA_WIDTH +: DATA_WIDTH])
        );

        nbody_bank_ram #(.WIDTH(DATA_WIDTH), .ADDR_W(BODY_ADDR_WIDTH)) u_init_vel (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (init_we_ok && (sel == SEL_W'(vel_sel(d)))),
            .waddr (idx),
            .wdata (writedata),
            .re    (core_init_rd_en),
            .raddr (core_init_rd_idx),
            .rdata (core_init_vel[d*DATA_WIDTH +: DATA_WIDTH])
        );

        nbody_bank_ram #(.WIDTH(DATA_WIDTH), .ADDR_W(BODY_ADDR_WIDTH)) u_bank0 (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (host_bank_we || core_we0),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (rd),
            .raddr (idx),
            .rdata (bank_rd0)
        );

        nbody_bank_ram #(.WIDTH(DATA_WIDTH), .ADDR_W(BODY_ADDR_WIDTH)) u_bank1 (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (host_bank_we || core_we1),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (rd),
            .raddr (idx),
            .rdata (bank_rd1)
        );

        assign front_rd[d*DATA_WIDTH +: DATA_WIDTH] = rd_bank_q ? bank_rd1 : bank_rd0;
    end

    always_comb begin
        readdata = rd_reg_q;
        if (rd_pos_q) begin
            readdata = front_rd[int'(rd_dim_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            core_start    <= 1'b0;
            core_stop     <= 1'b0;
            core_n_bodies <= '0;
            gap           <= 32'd1;
            steps         <= '0;
            step_cnt      <= '0;
            gap_cnt       <= '0;
            err           <= 1'b0;
            lock          <= 1'b0;
            swap_pending  <= 1'b0;
            bank_sel      <= 1'b0;
            rd_pos_q      <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_dim_q      <= '0;
            rd_reg_q      <= '0;
        end else begin
            core_start <= 1'b0;
            core_stop  <= 1'b0;

            if (wr && sel == SEL_W'(SEL_N_BODIES)) begin
                core_n_bodies <= (writedata > DATA_WIDTH'(NB_MAX)) ? NB_W'(NB_MAX)
                                                                    : writedata[NB_W-1:0];
            end
            if (wr && sel == SEL_W'(SEL_GAP)) begin
                gap <= writedata[31:0];
            end
            if (wr && sel == SEL_W'(SEL_STEPS)) begin
                steps <= writedata[31:0];
            end
            if (wr && body_sel && state == ST_RUN) begin
                err <= 1'b1;
            end

            lock         <= lock_next;
            swap_pending <= !do_swap && lock_next && (swap_due || swap_pending);
            if (do_swap) begin
                bank_sel <= !bank_sel;
            end

            if (stepping && core_step_done) begin
                step_cnt <= step_cnt + 32'd1;
                gap_cnt  <= (gap_cnt >= gap_eff - 32'd1) ? 32'd0 : gap_cnt + 32'd1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go_start) begin
                        state      <= ST_RUN;
                        step_cnt   <= '0;
                        gap_cnt    <= '0;
                        err        <= 1'b0;
                        core_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (go_stop || (steps != 32'd0 && step_cnt == steps)) begin
                        state     <= ST_STOPPING;
                        core_stop <= 1'b1;
                    end
                end
                ST_STOPPING: begin
                    if (!core_busy) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Remember which bank was front at request time; the RAM data lands next cycle.
            if (rd) begin
                rd_pos_q  <= 1'b0;
                rd_bank_q <= bank_sel;
                rd_reg_q  <= '0;
                if (sel == SEL_W'(SEL_STATUS)) begin
                    rd_reg_q <= status_word;
                end
                if (sel == SEL_W'(SEL_PERF)) begin
                    rd_reg_q <= perf_val;
                end
                for (int d = 0; d < DIMS; d++) begin
                    if (sel == SEL_W'(int'(SEL_READ_X) + d)) begin
                        rd_pos_q <= 1'b1;
                        rd_dim_q <= 2'(d);
                    end
                end
            end
        end
    end

endmodule
